// File: rtl/quote_scheduler.sv
// Shares one valid/ready quote output among NUM_STOCKS generators: one latest-quote slot
// per stock, a per-stock cooldown, and round-robin grants into a single output register.
module quote_scheduler #(
  parameter int NUM_STOCKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8,
  parameter int SID_W      = $clog2(NUM_STOCKS)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_STOCKS-1:0]            i_req_valid,
  input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_buy_price,
  input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_sell_price,
  input  logic [NUM_STOCKS*QTY_WIDTH-1:0]  i_quantity,
  input  logic [GAP_WIDTH-1:0]             i_min_gap,
  input  logic                             i_out_ready,
  output logic                             o_valid,
  output logic [SID_W-1:0]                 o_stock_id,
  output logic [DATA_WIDTH-1:0]            o_buy_price,
  output logic [DATA_WIDTH-1:0]            o_sell_price,
  output logic [QTY_WIDTH-1:0]             o_quantity,
  output logic [NUM_STOCKS-1:0]            o_pending,
  output logic [15:0]                      o_overwrite_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   buy_q  [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   buy_d  [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   sell_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   sell_d [NUM_STOCKS];
  logic [QTY_WIDTH-1:0]    qty_q  [NUM_STOCKS];
  logic [QTY_WIDTH-1:0]    qty_d  [NUM_STOCKS];
  logic [GAP_WIDTH-1:0]    cool_q [NUM_STOCKS];
  logic [GAP_WIDTH-1:0]    cool_d [NUM_STOCKS];
  logic [NUM_STOCKS-1:0]   pending_q, pending_d;
  logic [SID_W-1:0]        last_q, last_d;
  logic [SID_W-1:0]        out_sid_q, out_sid_d;
  logic [DATA_WIDTH-1:0]   out_buy_q, out_buy_d;
  logic [DATA_WIDTH-1:0]   out_sell_q, out_sell_d;
  logic [QTY_WIDTH-1:0]    out_qty_q, out_qty_d;
  logic [15:0]             ovw_q, ovw_d;

  logic [NUM_STOCKS-1:0]   eligible;
  logic [NUM_STOCKS-1:0]   gnt_vec;
  logic [NUM_STOCKS-1:0]   ovw_vec;
  logic                    gnt_found;
  logic [SID_W-1:0]        gnt_sel;
  logic                    grant_slot_open;
  logic                    do_grant;

  // Returns {found, index}: first eligible stock searching from last+1, wrapping.
  function automatic logic [SID_W:0] rr_pick(input logic [SID_W-1:0]      last,
                                             input logic [NUM_STOCKS-1:0] elig);
    logic [SID_W:0] res;
    int             idx;
    res = '0;
    for (int i = 1; i <= NUM_STOCKS; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_STOCKS) idx = idx - NUM_STOCKS;
      if (!res[SID_W] && elig[SID_W'(idx)]) res = {1'b1, SID_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    eligible = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      eligible[s] = pending_q[s] && (cool_q[s] == '0);
    end
  end

  always_comb begin
    {gnt_found, gnt_sel} = rr_pick(last_q, eligible);
    // A new grant may load the output register when it is empty or being drained.
    grant_slot_open = (state_q == IDLE) || i_out_ready;
    do_grant        = grant_slot_open && gnt_found;

    state_d    = state_q;
    last_d     = last_q;
    out_sid_d  = out_sid_q;
    out_buy_d  = out_buy_q;
    out_sell_d = out_sell_q;
    out_qty_d  = out_qty_q;
    ovw_d      = ovw_q;
    pending_d  = pending_q;
    buy_d      = buy_q;
    sell_d     = sell_q;
    qty_d      = qty_q;
    cool_d     = cool_q;
    gnt_vec    = '0;
    ovw_vec    = '0;

    if (do_grant) begin
      state_d    = SEND;
      last_d     = gnt_sel;
      out_sid_d  = gnt_sel;
      out_buy_d  = buy_q[gnt_sel];
      out_sell_d = sell_q[gnt_sel];
      out_qty_d  = qty_q[gnt_sel];
    end else if (state_q == SEND && i_out_ready) begin
      state_d = IDLE;
    end

    for (int s = 0; s < NUM_STOCKS; s++) begin
      gnt_vec[s] = do_grant && (gnt_sel == SID_W'(s));
      if (gnt_vec[s]) begin
        pending_d[s] = 1'b0;
        cool_d[s]    = i_min_gap;
      end else if (cool_q[s] != '0) begin
        cool_d[s] = cool_q[s] - GAP_WIDTH'(1);
      end
      // A same-edge request wins over the grant's pending clear; grant already took old data.
      if (i_req_valid[s]) begin
        if (i_quantity[s*QTY_WIDTH +: QTY_WIDTH] != '0) begin
          buy_d[s]     = i_buy_price[s*DATA_WIDTH +: DATA_WIDTH];
          sell_d[s]    = i_sell_price[s*DATA_WIDTH +: DATA_WIDTH];
          qty_d[s]     = i_quantity[s*QTY_WIDTH +: QTY_WIDTH];
          pending_d[s] = 1'b1;
          ovw_vec[s]   = pending_q[s] && !gnt_vec[s];
        end else begin
          pending_d[s] = 1'b0;
        end
      end
      if (ovw_vec[s] && ovw_d != 16'hFFFF) ovw_d = ovw_d + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      last_q     <= SID_W'(NUM_STOCKS - 1);
      out_sid_q  <= '0;
      out_buy_q  <= '0;
      out_sell_q <= '0;
      out_qty_q  <= '0;
      ovw_q      <= '0;
      pending_q  <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        buy_q[s]  <= '0;
        sell_q[s] <= '0;
        qty_q[s]  <= '0;
        cool_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      out_sid_q  <= out_sid_d;
      out_buy_q  <= out_buy_d;
      out_sell_q <= out_sell_d;
      out_qty_q  <= out_qty_d;
      ovw_q      <= ovw_d;
      pending_q  <= pending_d;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        buy_q[s]  <= buy_d[s];
        sell_q[s] <= sell_d[s];
        qty_q[s]  <= qty_d[s];
        cool_q[s] <= cool_d[s];
      end
    end
  end

  assign o_valid           = (state_q == SEND);
  assign o_stock_id        = out_sid_q;
  assign o_buy_price       = out_buy_q;
  assign o_sell_price      = out_sell_q;
  assign o_quantity        = out_qty_q;
  assign o_pending         = pending_q;
  assign o_overwrite_count = ovw_q;

endmodule

// File: doc/quote_scheduler.md
# quote_scheduler

Shares the single order-output path (reverse parser) among the per-stock quote generators. Holds one latest-quote slot per stock and rate-limits each stock with a programmable cooldown. Grants eligible stocks round-robin onto one valid/ready output register. Sits between trading_logic/order_quantity and reverse_parser.

## Interface
- NUM_STOCKS, 4: number of stocks/requesters; ID width SID_W = $clog2(NUM_STOCKS)
- DATA_WIDTH, 32: price width
- QTY_WIDTH, 16: quantity width
- GAP_WIDTH, 8: cooldown counter width
- i_clk  in  1  single clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_STOCKS  per-stock quote strobe
- i_buy_price  in  NUM_STOCKS*DATA_WIDTH  packed; stock s at [s*DATA_WIDTH +: DATA_WIDTH]
- i_sell_price  in  NUM_STOCKS*DATA_WIDTH  packed, same layout
- i_quantity  in  NUM_STOCKS*QTY_WIDTH  packed; 0 = cancel
- i_min_gap  in  GAP_WIDTH  per-stock cooldown cycles; 0 = no throttle
- i_out_ready  in  1  reverse parser accepts output
- o_valid  out  1  output quote valid
- o_stock_id  out  SID_W  stock of output quote
- o_buy_price, o_sell_price  out  DATA_WIDTH  output prices
- o_quantity  out  QTY_WIDTH  output quantity
- o_pending  out  NUM_STOCKS  slot-occupied flags
- o_overwrite_count  out  16  saturating count of superseded quotes

## Operation
- Slot s (prices, quantity, pending) is captured when i_req_valid[s]=1.
  - Quantity ≠ 0: slot loaded, pending=1.
  - Quantity = 0: pending cleared, slot data unchanged; never output.
- Overwrite: request with quantity ≠ 0 for a slot that is pending and not granted this cycle. Newest data wins; o_overwrite_count += 1, saturating at 0xFFFF.
- Cooldown[s]: loaded with i_min_gap when s is granted; otherwise decrements by 1 while nonzero.
- Eligible[s] = pending[s] && cooldown[s]==0.
- Arbitration: round-robin, search starting at last_grant+1 modulo NUM_STOCKS.
- Grant (at one edge):
  - output register loaded from slot s;
  - pending[s] cleared;
  - cooldown[s] loaded;
  - last_grant=s.
- FSM, two states:
  - IDLE (o_valid=0): if any eligible, grant and go SEND.
  - SEND (o_valid=1): outputs held stable while i_out_ready=0. On i_out_ready=1:
    - any eligible: grant in the same edge, stay SEND (back-to-back);
    - else go IDLE.
- Simultaneous request and grant of the same slot: grant uses the old slot contents. The new request is captured with pending=1; it is not an overwrite.
- Simultaneous cancel and grant: the grant proceeds with the old contents; pending ends 0.
- Request during cooldown: captured, waits until cooldown reaches 0.
- Reset (mid-operation included):
  - all outputs 0 (o_valid, o_stock_id, prices, quantity, o_pending, o_overwrite_count);
  - slots cleared, cooldowns 0, FSM IDLE;
  - last_grant=NUM_STOCKS-1, so stock 0 has priority first.
  - An in-flight o_valid is dropped without handshake.

## Timing
- Request sampled at edge E0 → o_pending set after E0.
- Output loaded at E1 → o_valid high after E1. Minimum latency: 2 edges.
- Handshake completes at an edge where o_valid && i_out_ready. Max throughput: 1 quote/cycle across stocks.
- Same-stock spacing: grant at edge t → earliest next grant of that stock at edge t+1+i_min_gap.
- i_min_gap is sampled at grant time; changing it does not affect running cooldowns.
- o_pending and o_overwrite_count are registered and update at the same edge as slot changes.

## Test plan
- Reset, then i_req_valid=0001, buy=100, sell=102, qty=5, i_out_ready=1:
  - o_valid high 2 edges after request;
  - o_stock_id=0, 100/102/5;
  - o_pending returns to 0.
- Requests on stocks 0–3 in one cycle, i_out_ready=1, i_min_gap=0:
  - grants 0,1,2,3 on consecutive cycles;
  - next round of requests starts after stock 3.
- i_out_ready=0 for 5 cycles with o_valid=1; stock 2 requests twice meanwhile:
  - outputs stay stable;
  - o_overwrite_count=1;
  - after ready, stock 2 is output with the second request's data.
- i_min_gap=3; stock 1 requests every cycle, ready=1:
  - stock 1 grants spaced exactly 4 edges apart.
- Stock 3 pending; qty=0 request on stock 3 before grant:
  - o_pending[3]=0;
  - no output;
  - overwrite count unchanged.
- Assert i_reset while o_valid=1 with two slots pending:
  - next cycle all outputs 0;
  - first post-reset grant goes to stock 0 when stocks 0 and 2 both request.
